// File: rtl/aq_ifu_ras_pkg.sv
// Shared constants and width helpers for the IFU return address stack.
package aq_ifu_ras_pkg;

  localparam int unsigned RAS_DEPTH    = 6;
  localparam int unsigned RAS_PC_WIDTH = 40;
  // Byte size of one instruction; a link pushes pc + INST_SIZE.
  localparam int unsigned INST_SIZE    = 4;

  function automatic int unsigned ras_ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned ras_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  localparam int unsigned RAS_PTR_W = ras_ptr_w(RAS_DEPTH);
  localparam int unsigned RAS_CNT_W = ras_cnt_w(RAS_DEPTH);

endpackage

// File: rtl/aq_ifu_ras_stack.sv
// Circular return address stack: entry array, top pointer and occupancy count.
// Exposes both current and next state so another stack can be restored from it.
module aq_ifu_ras_stack
  import aq_ifu_ras_pkg::*;
#(
  parameter int unsigned DEPTH    = RAS_DEPTH,
  parameter int unsigned PC_WIDTH = RAS_PC_WIDTH,
  localparam int unsigned PTR_W   = ras_ptr_w(DEPTH),
  localparam int unsigned CNT_W   = ras_cnt_w(DEPTH)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               push,
  input  logic                               pop,
  input  logic [PC_WIDTH-1:0]                addr,
  input  logic                               load,
  input  logic [DEPTH-1:0][PC_WIDTH-1:0]     load_entries,
  input  logic [PTR_W-1:0]                   load_top,
  input  logic [CNT_W-1:0]                   load_count,
  output logic [DEPTH-1:0][PC_WIDTH-1:0]     entries,
  output logic [PTR_W-1:0]                   top,
  output logic [CNT_W-1:0]                   count,
  output logic [DEPTH-1:0][PC_WIDTH-1:0]     entries_nxt,
  output logic [PTR_W-1:0]                   top_nxt,
  output logic [CNT_W-1:0]                   count_nxt
);

  localparam logic [PTR_W-1:0] TopMax = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEPTH);

  logic [DEPTH-1:0][PC_WIDTH-1:0] entries_q, entries_d;
  logic [PTR_W-1:0]               top_q, top_d;
  logic [CNT_W-1:0]               count_q, count_d;
  logic [PTR_W-1:0]               top_inc, top_dec;
  logic                           nonempty;

  // Modulo-DEPTH pointer neighbours; DEPTH need not be a power of two.
  always_comb begin
    top_inc  = (top_q == TopMax) ? '0 : top_q + PTR_W'(1);
    top_dec  = (top_q == '0) ? TopMax : top_q - PTR_W'(1);
    nonempty = (count_q != '0);
  end

  // Next-state: load wins, then push+pop replace, push, pop.
  always_comb begin
    entries_d = entries_q;
    top_d     = top_q;
    count_d   = count_q;
    if (load) begin
      entries_d = load_entries;
      top_d     = load_top;
      count_d   = load_count;
    end else if (push && pop && nonempty) begin
      entries_d[top_q] = addr;
    end else if (push) begin
      // When full the oldest entry is overwritten; count saturates.
      top_d            = top_inc;
      entries_d[top_inc] = addr;
      count_d          = (count_q == CntMax) ? count_q : count_q + CNT_W'(1);
    end else if (pop && nonempty) begin
      top_d   = top_dec;
      count_d = count_q - CNT_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries_q <= '0;
      top_q     <= TopMax;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      top_q     <= top_d;
      count_q   <= count_d;
    end
  end

  assign entries     = entries_q;
  assign top         = top_q;
  assign count       = count_q;
  assign entries_nxt = entries_d;
  assign top_nxt     = top_d;
  assign count_nxt   = count_d;

endmodule

// File: rtl/aq_ifu_ras.sv
// IFU return address stack: speculative stack for fetch prediction, retired
// stack tracking committed calls/returns, flush restores speculative from retired.
module aq_ifu_ras
  import aq_ifu_ras_pkg::*;
#(
  parameter int unsigned DEPTH    = RAS_DEPTH,
  parameter int unsigned PC_WIDTH = RAS_PC_WIDTH
) (
  input  logic                forever_cpuclk,
  input  logic                cpurst_b,
  input  logic                pred_link_vld0,
  input  logic                pred_ret_vld0,
  input  logic [PC_WIDTH-1:0] ipack_pred_pc0,
  input  logic                ifu_ras_stall,
  input  logic                rtu_ifu_retire_link_vld,
  input  logic                rtu_ifu_retire_ret_vld,
  input  logic [PC_WIDTH-1:0] rtu_ifu_retire_pc,
  input  logic                rtu_ifu_flush,
  output logic                ras_pred_vld,
  output logic [PC_WIDTH-1:0] ras_pred_target,
  output logic                ras_empty,
  output logic                ras_full
);

  localparam int unsigned PTR_W = ras_ptr_w(DEPTH);
  localparam int unsigned CNT_W = ras_cnt_w(DEPTH);

  logic                           spec_push, spec_pop;
  logic [PC_WIDTH-1:0]            spec_addr, rtd_addr;

  logic [DEPTH-1:0][PC_WIDTH-1:0] spec_entries, spec_entries_nxt;
  logic [PTR_W-1:0]               spec_top, spec_top_nxt;
  logic [CNT_W-1:0]               spec_count, spec_count_nxt;

  logic [DEPTH-1:0][PC_WIDTH-1:0] rtd_entries, rtd_entries_nxt;
  logic [PTR_W-1:0]               rtd_top, rtd_top_nxt;
  logic [CNT_W-1:0]               rtd_count, rtd_count_nxt;

  // Request gating and return-address generation (pc + 4, wraps).
  always_comb begin
    spec_push = pred_link_vld0 & ~ifu_ras_stall & ~rtu_ifu_flush;
    spec_pop  = pred_ret_vld0 & ~ifu_ras_stall & ~rtu_ifu_flush;
    spec_addr = ipack_pred_pc0 + PC_WIDTH'(INST_SIZE);
    rtd_addr  = rtu_ifu_retire_pc + PC_WIDTH'(INST_SIZE);
  end

  aq_ifu_ras_stack #(
    .DEPTH    (DEPTH),
    .PC_WIDTH (PC_WIDTH)
  ) u_spec_stack (
    .clk          (forever_cpuclk),
    .rst_n        (cpurst_b),
    .push         (spec_push),
    .pop          (spec_pop),
    .addr         (spec_addr),
    .load         (rtu_ifu_flush),
    .load_entries (rtd_entries_nxt),
    .load_top     (rtd_top_nxt),
    .load_count   (rtd_count_nxt),
    .entries      (spec_entries),
    .top          (spec_top),
    .count        (spec_count),
    .entries_nxt  (spec_entries_nxt),
    .top_nxt      (spec_top_nxt),
    .count_nxt    (spec_count_nxt)
  );

  aq_ifu_ras_stack #(
    .DEPTH    (DEPTH),
    .PC_WIDTH (PC_WIDTH)
  ) u_rtd_stack (
    .clk          (forever_cpuclk),
    .rst_n        (cpurst_b),
    .push         (rtu_ifu_retire_link_vld),
    .pop          (rtu_ifu_retire_ret_vld),
    .addr         (rtd_addr),
    .load         (1'b0),
    .load_entries ('0),
    .load_top     ('0),
    .load_count   ('0),
    .entries      (rtd_entries),
    .top          (rtd_top),
    .count        (rtd_count),
    .entries_nxt  (rtd_entries_nxt),
    .top_nxt      (rtd_top_nxt),
    .count_nxt    (rtd_count_nxt)
  );

  // Only the speculative current state and retired next state are consumed.
  logic unused_state;
  assign unused_state = ^{rtd_entries, rtd_top, rtd_count,
                          spec_entries_nxt, spec_top_nxt, spec_count_nxt};

  // Prediction and status outputs from the speculative stack.
  always_comb begin
    ras_pred_vld    = spec_pop & (spec_count != '0);
    ras_pred_target = (spec_count != '0) ? spec_entries[spec_top] : '0;
    ras_empty       = (spec_count == '0);
    ras_full        = (spec_count == CNT_W'(DEPTH));
  end

endmodule

// File: tb/tb_aq_ifu_ras.sv
// Scoreboard bench for aq_ifu_ras: stimulus queues the expected prediction for
// every return request; a negedge monitor pops and compares.
module tb_aq_ifu_ras;

  localparam int unsigned PW = 40;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          link, ret, stall, flush, rlink, rret;
  logic [PW-1:0] pc, rpc;
  logic          pred_vld, empty, full;
  logic [PW-1:0] target;

  typedef struct {
    logic          vld;
    logic [PW-1:0] tgt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic mon_en   = 1'b0;

  always #5 clk = ~clk;

  aq_ifu_ras #(
    .DEPTH    (6),
    .PC_WIDTH (PW)
  ) dut (
    .forever_cpuclk          (clk),
    .cpurst_b                (rst_b),
    .pred_link_vld0          (link),
    .pred_ret_vld0           (ret),
    .ipack_pred_pc0          (pc),
    .ifu_ras_stall           (stall),
    .rtu_ifu_retire_link_vld (rlink),
    .rtu_ifu_retire_ret_vld  (rret),
    .rtu_ifu_retire_pc       (rpc),
    .rtu_ifu_flush           (flush),
    .ras_pred_vld            (pred_vld),
    .ras_pred_target         (target),
    .ras_empty               (empty),
    .ras_full                (full)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic step(input logic l, input logic r, input logic [PW-1:0] p,
                      input logic s, input logic f,
                      input logic rl, input logic rr, input logic [PW-1:0] rp);
    link = l; ret = r; pc = p; stall = s; flush = f;
    rlink = rl; rret = rr; rpc = rp;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [PW-1:0] p);
    step(1'b1, 1'b0, p, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic pop(input logic v, input logic [PW-1:0] t);
    exp_q.push_back('{vld: v, tgt: t});
    step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic flags(input string name, input logic e, input logic fu);
    chk({name, "_empty"}, {63'd0, empty}, {63'd0, e});
    chk({name, "_full"}, {63'd0, full}, {63'd0, fu});
  endtask

  // Monitor: compare each effective return request against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ret && !stall && !flush) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: got request, expected none queued");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pred_vld", {63'd0, pred_vld}, {63'd0, e.vld});
          if (e.vld) chk("pred_target", {24'd0, target}, {24'd0, e.tgt});
        end
      end else begin
        chk("idle_vld", {63'd0, pred_vld}, 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    link = 0; ret = 0; pc = '0; stall = 0; flush = 0; rlink = 0; rret = 0; rpc = '0;
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_b = 1'b1;
    chk("rst_pred_vld", {63'd0, pred_vld}, 64'd0);
    chk("rst_target", {24'd0, target}, 64'd0);
    flags("rst", 1'b1, 1'b0);
    mon_en = 1'b1;

    // Return on an empty stack: no prediction, no state change.
    pop(1'b0, '0);
    flags("empty_pop", 1'b1, 1'b0);

    // Two-deep push/pop.
    push(40'h1000);
    push(40'h2000);
    pop(1'b1, 40'h2004);
    pop(1'b1, 40'h1004);
    flags("two_deep", 1'b1, 1'b0);

    // Overflow: 7 pushes into 6 entries overwrites the oldest.
    for (int i = 0; i < 7; i++) begin
      push(40'(i * 16));
      if (i == 4) flags("five_push", 1'b0, 1'b0);
      if (i == 5) flags("six_push", 1'b0, 1'b1);
    end
    flags("seven_push", 1'b0, 1'b1);
    for (int i = 6; i >= 1; i--) pop(1'b1, 40'(i * 16 + 4));
    pop(1'b0, '0);
    flags("overflow_drain", 1'b1, 1'b0);

    // Simultaneous push and pop replaces the top entry.
    push(40'h100);
    exp_q.push_back('{vld: 1'b1, tgt: 40'h104});
    step(1'b1, 1'b1, 40'h200, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    flags("push_pop", 1'b0, 1'b0);
    pop(1'b1, 40'h204);
    flags("push_pop_drain", 1'b1, 1'b0);

    // Flush restores the retired stack; same-cycle link is ignored.
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 40'h300);
    push(40'h400);
    push(40'h500);
    step(1'b1, 1'b0, 40'h600, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    flags("flush", 1'b0, 1'b0);
    pop(1'b1, 40'h304);
    flags("flush_pop", 1'b1, 1'b0);
    pop(1'b0, '0);

    // Stall blocks a link; pc + 4 wraps from the top of the address space.
    step(1'b1, 1'b0, 40'h700, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    flags("stall", 1'b1, 1'b0);
    push(40'hFF_FFFF_FFFC);
    flags("wrap_push", 1'b0, 1'b0);
    pop(1'b1, 40'h0);
    flags("wrap_pop", 1'b1, 1'b0);

    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    chk("sb_drain", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
